serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor. Computes Diff = A - B - Bin, one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop.
- Provides the subtraction direction of the ripple-carry adder datapath in area-constrained paths.
- Uses a start/busy/done handshake so a controller can launch it and wait for the result.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int WIDTH_MAX = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B - Bin), LSB first, start/busy/done handshake.
// Optional signed-overflow flag on port ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// SHIFT | one result bit per cycle through the full-subtractor cell
// DONE  | publish Diff/Bout, pulse done, return to IDLE
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = clog2(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit, br_nxt;

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Result bits enter at the MSB so the LSB computed first ends up at bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         done <= 1'b0;
         Diff <= '0;
         Bout <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= A;
                  b_sh <= B;
                  br   <= Bin;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nxt;
               res  <= {d_bit, res[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
            end
            DONE: begin
               done <= 1'b1;
               Diff <= res;
               Bout <= br;
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_sgn, b_sgn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sgn <= 1'b0;
         b_sgn <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_sgn <= A[WIDTH-1];
            b_sgn <= B[WIDTH-1];
         end
         if (state == DONE) ovf <= (a_sgn != b_sgn) & (res[WIDTH-1] != a_sgn);
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) with an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A     = '0;
   logic [W-1:0] B     = '0;
   logic         Bin   = 1'b0;
   logic         busy, done, Bout;
   logic [W-1:0] Diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted operation finishes WIDTH+1 edges later with plain integer arithmetic.
   int           cyc    = 0;
   int           acc    = 0;
   bit           active = 1'b0;
   int           pa = 0, pb = 0, pbin = 0;
   logic [W-1:0] md     = '0;
   logic         mb     = 1'b0;
   logic         mo     = 1'b0;
   logic         mdone  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; active = 1'b0; md = '0; mb = 1'b0; mo = 1'b0; mdone = 1'b0;
      end else begin
         cyc++;
         mdone = 1'b0;
         if (active) begin
            if (cyc == acc + W + 1) begin
               int sa, sb, s;
               active = 1'b0;
               mdone  = 1'b1;
               md     = W'((pa - pb - pbin) & ((1 << W) - 1));
               mb     = (pa < pb + pbin);
               sa     = (pa >= (1 << (W - 1))) ? pa - (1 << W) : pa;
               sb     = (pb >= (1 << (W - 1))) ? pb - (1 << W) : pb;
               s      = sa - sb - pbin;
               mo     = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
            end
         end else if (start) begin
            active = 1'b1;
            acc    = cyc;
            pa     = int'(A);
            pb     = int'(B);
            pbin   = int'(Bin);
         end
      end
   end

   always @(negedge clk) begin
      chk("done", 32'(done), 32'(mdone));
      chk("busy", 32'(busy), 32'(active));
      chk("Diff", 32'(Diff), 32'(md));
      chk("Bout", 32'(Bout), 32'(mb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("ovf", 32'(ovf), 32'(mo));
`endif
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic o,
                         output int nd, output int lat);
      nd = 0; lat = 0; d = 'x; bo = 1'bx; o = 1'bx;
      @(negedge clk); #1;
      A = a; B = b; Bin = bin; start = 1'b1;
      for (int i = 1; i <= W + 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            nd++;
            if (lat == 0) lat = i;
            d  = Diff;
            bo = Bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            o  = ovf;
`else
            o  = 1'b0;
`endif
         end
         if (i == 1) begin
            #1;
            start = 1'b0;
            A = W'($urandom_range(15));
            B = W'($urandom_range(15));
            Bin = 1'($urandom_range(1));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] d;
      logic         bo, o;
      int           nd, lat;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(Diff), 32'd0);
      chk("rst_bout", 32'(Bout), 32'd0);
      #1 rst_n = 1'b1;

      run_op(4'd5, 4'd3, 1'b0, d, bo, o, nd, lat);
      chk("t1_diff", 32'(d), 32'h2);
      chk("t1_bout", 32'(bo), 32'd0);
      chk("t1_ndone", 32'(nd), 32'd1);
      chk("t1_latency", 32'(lat), 32'd6);
      chk("t1_busy_after", 32'(busy), 32'd0);

      run_op(4'd2, 4'd1, 1'b1, d, bo, o, nd, lat);
      chk("t2a_diff", 32'(d), 32'h0);
      chk("t2a_bout", 32'(bo), 32'd0);
      run_op(4'd0, 4'd1, 1'b0, d, bo, o, nd, lat);
      chk("t2b_diff", 32'(d), 32'hF);
      chk("t2b_bout", 32'(bo), 32'd1);

      run_op(4'd15, 4'd15, 1'b1, d, bo, o, nd, lat);
      chk("t3_diff", 32'(d), 32'hF);
      chk("t3_bout", 32'(bo), 32'd1);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               run_op(W'(a), W'(b), 1'(c), d, bo, o, nd, lat);
               chk("sweep_ndone", 32'(nd), 32'd1);
            end

      // Start pulse during SHIFT must not disturb the operation in flight.
      @(negedge clk); #1;
      A = 4'd9; B = 4'd4; Bin = 1'b0; start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      @(negedge clk); #1;
      A = 4'd1; B = 4'd1; start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      nd = 0; d = 'x;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin nd++; d = Diff; end
      end
      chk("t4_ndone", 32'(nd), 32'd1);
      chk("t4_diff", 32'(d), 32'h5);

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk); #1;
      A = 4'd7; B = 4'd2; Bin = 1'b0; start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_diff", 32'(Diff), 32'd0);
      chk("t5_bout", 32'(Bout), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      chk("t5_no_done", 32'(nd), 32'd0);
      run_op(4'd7, 4'd2, 1'b0, d, bo, o, nd, lat);
      chk("t5_after_diff", 32'(d), 32'h5);
      chk("t5_after_bout", 32'(bo), 32'd0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
      run_op(4'b1000, 4'b0001, 1'b0, d, bo, o, nd, lat);
      chk("t6a_diff", 32'(d), 32'h7);
      chk("t6a_ovf", 32'(o), 32'd1);
      run_op(4'b0011, 4'b0001, 1'b0, d, bo, o, nd, lat);
      chk("t6b_diff", 32'(d), 32'h2);
      chk("t6b_ovf", 32'(o), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
